// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Sequences and arbitrates the CPU's single-port data memory between the
//   core load/store path and a DMA/loader requester. Each access runs as an
//   IDLE -> ACCESS -> ACK transaction; the core is stalled until its access
//   retires, and core loads return to the register file as a load_en pulse.
//
// Parameters
//   MEM_LAT    : cycles from mem_re rise to valid mem_rdata (1..7)
//   STARVE_LIM : consecutive core grants allowed while DMA waits (1..15)
//
// Ports
//   clk, rst_n                       : clock, async active-low reset
//   core_req/we/addr/wdata           : core request, held until core_ack
//   core_ack, core_stall             : core retire pulse, PC hold
//   load_en, load_data               : register-file load pulse and byte
//   dma_req/we/addr/wdata            : DMA request, held until dma_ack
//   dma_ack, dma_rdata               : DMA retire pulse and read byte
//   mem_addr, mem_wdata, mem_we,
//   mem_re, mem_rdata                : single-port memory interface
//   busy                             : transaction in progress
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       core_req,
  input  logic       core_we,
  input  logic [7:0] core_addr,
  input  logic [7:0] core_wdata,
  output logic       core_ack,
  output logic       core_stall,
  output logic       load_en,
  output logic [7:0] load_data,
  input  logic       dma_req,
  input  logic       dma_we,
  input  logic [7:0] dma_addr,
  input  logic [7:0] dma_wdata,
  output logic       dma_ack,
  output logic [7:0] dma_rdata,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       mem_re,
  input  logic [7:0] mem_rdata,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_ACK
  } state_t;

  localparam logic [2:0] READ_WAIT  = 3'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

  state_t     r_state;
  state_t     w_next;

  logic       r_owner_dma;
  logic       r_we;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic [2:0] r_wait_cnt;
  logic [3:0] r_starve_cnt;
  logic [7:0] r_load_data;
  logic [7:0] r_dma_rdata;

  logic       w_grant;
  logic       w_grant_dma;
  logic       w_sel_we;
  logic [7:0] w_sel_addr;
  logic [7:0] w_sel_wdata;
  logic       w_access_done;
  logic       w_core_ack;

  // Arbitration: core wins ties unless DMA has waited through STARVE_LIM
  // consecutive core grants.
  always_comb begin
    w_grant       = (r_state == S_IDLE) && (core_req || dma_req);
    w_grant_dma   = dma_req && (!core_req || (r_starve_cnt == STARVE_MAX));
    w_sel_we      = w_grant_dma ? dma_we    : core_we;
    w_sel_addr    = w_grant_dma ? dma_addr  : core_addr;
    w_sel_wdata   = w_grant_dma ? dma_wdata : core_wdata;
    w_access_done = (r_state == S_ACCESS) && (r_wait_cnt == '0);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_grant) w_next = S_ACCESS;
      S_ACCESS: if (r_wait_cnt == '0) w_next = S_ACK;
      S_ACK:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Transaction datapath: latched request, latency and starvation counters,
  // read-data holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner_dma  <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wait_cnt   <= '0;
      r_starve_cnt <= '0;
      r_load_data  <= '0;
      r_dma_rdata  <= '0;
    end else begin
      if (w_grant) begin
        r_owner_dma <= w_grant_dma;
        r_we        <= w_sel_we;
        r_addr      <= w_sel_addr;
        r_wdata     <= w_sel_wdata;
        r_wait_cnt  <= w_sel_we ? '0 : READ_WAIT;
        if (w_grant_dma || !dma_req) begin
          r_starve_cnt <= '0;
        end else if (r_starve_cnt != STARVE_MAX) begin
          r_starve_cnt <= r_starve_cnt + 4'd1;
        end
      end else if ((r_state == S_ACCESS) && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - 3'd1;
      end

      if (w_access_done && !r_we) begin
        if (r_owner_dma) begin
          r_dma_rdata <= mem_rdata;
        end else begin
          r_load_data <= mem_rdata;
        end
      end
    end
  end

  // Outputs. The memory address/data buses come straight from the latched
  // request registers, which only change on a grant, so they hold their last
  // value outside ACCESS.
  always_comb begin
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    w_core_ack = 1'b0;
    dma_ack    = 1'b0;
    load_en    = 1'b0;
    unique case (r_state)
      S_ACCESS: begin
        mem_we = r_we;
        mem_re = !r_we;
      end
      S_ACK: begin
        w_core_ack = !r_owner_dma;
        dma_ack    = r_owner_dma;
        load_en    = !r_owner_dma && !r_we;
      end
      default: ;
    endcase
    core_ack   = w_core_ack;
    core_stall = core_req && !w_core_ack;
    busy       = (r_state != S_IDLE);
    mem_addr   = r_addr;
    mem_wdata  = r_wdata;
    load_data  = r_load_data;
    dma_rdata  = r_dma_rdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-timeline model.
module tb_mem_port_arbiter;

  localparam int unsigned MEM_LAT    = 2;
  localparam int unsigned STARVE_LIM = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       core_req, core_we;
  logic [7:0] core_addr, core_wdata;
  logic       core_ack, core_stall, load_en;
  logic [7:0] load_data;
  logic       dma_req, dma_we;
  logic [7:0] dma_addr, dma_wdata;
  logic       dma_ack;
  logic [7:0] dma_rdata;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_we, mem_re;
  logic [7:0] mem_rdata;
  logic       busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_ack(core_ack), .core_stall(core_stall),
    .load_en(load_en), .load_data(load_data),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory stub: read data is only valid in the MEM_LAT-th cycle of a
  // continuous mem_re run; otherwise it returns a poison byte.
  bit [7:0]    smem [256];
  int unsigned re_run = 0;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0, pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) smem[pl_addr] <= pl_data;
    else if (mem_we) smem[mem_addr] <= mem_wdata;
    re_run <= mem_re ? re_run + 1 : 0;
  end
  assign mem_rdata = (mem_re && (re_run == MEM_LAT - 1)) ? smem[mem_addr] : 8'hEE;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: m_k counts cycles since the grant edge (0 = idle).
  // ACCESS spans k = 1..m_n, the ack cycle is k = m_n+1.
  int       m_k, m_n, m_starve;
  bit       m_dma, m_we;
  bit [7:0] m_addr, m_wdata, m_ld, m_dr;
  bit [7:0] m_mem [256];
  bit       ack_q [$];

  bit c_pend = 0, c_infl = 0, d_pend = 0, d_infl = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_k = 0; m_n = 0; m_starve = 0; m_dma = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; m_ld = '0; m_dr = '0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    m_mem[a] = d;
  endtask

  task automatic model_edge();
    if (m_k == 0) begin
      if (core_req || dma_req) begin
        m_dma = dma_req && (!core_req || (m_starve == STARVE_LIM));
        if (m_dma) m_starve = 0;
        else if (dma_req) m_starve = (m_starve < STARVE_LIM) ? m_starve + 1 : m_starve;
        else m_starve = 0;
        m_we    = m_dma ? dma_we    : core_we;
        m_addr  = m_dma ? dma_addr  : core_addr;
        m_wdata = m_dma ? dma_wdata : core_wdata;
        m_n     = m_we ? 1 : MEM_LAT;
        if (m_we) m_mem[m_addr] = m_wdata;
        m_k = 1;
      end
    end else if (m_k <= m_n) begin
      if ((m_k == m_n) && !m_we) begin
        if (m_dma) m_dr = m_mem[m_addr];
        else m_ld = m_mem[m_addr];
      end
      m_k++;
    end else begin
      m_k = 0;
    end
  endtask

  task automatic check_outputs();
    bit acc, ackc, e_cack, e_dack;
    acc    = (m_k >= 1) && (m_k <= m_n);
    ackc   = (m_k != 0) && (m_k == m_n + 1);
    e_cack = ackc && !m_dma;
    e_dack = ackc && m_dma;
    chk("busy",       busy,       32'(m_k != 0));
    chk("mem_re",     mem_re,     32'(acc && !m_we));
    chk("mem_we",     mem_we,     32'(acc && m_we));
    chk("mem_addr",   mem_addr,   32'(m_addr));
    chk("mem_wdata",  mem_wdata,  32'(m_wdata));
    chk("core_ack",   core_ack,   32'(e_cack));
    chk("dma_ack",    dma_ack,    32'(e_dack));
    chk("load_en",    load_en,    32'(e_cack && !m_we));
    chk("load_data",  load_data,  32'(m_ld));
    chk("dma_rdata",  dma_rdata,  32'(m_dr));
    chk("core_stall", core_stall, 32'(core_req && !e_cack));
    chk("one_ack",    32'(core_ack) + 32'(dma_ack), 32'(ackc));
    if (core_ack) ack_q.push_back(1'b0);
    if (dma_ack)  ack_q.push_back(1'b1);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    pl_en = 1'b0;
    check_outputs();
  endtask

  task automatic drive_random();
    bit cg, dg;
    cg = (m_k != 0) && !m_dma;
    dg = (m_k != 0) && m_dma;
    if (core_ack) begin
      c_pend = 0; c_infl = 0; core_req = 1'b0;
    end else if (c_pend) begin
      if (!cg && ($urandom_range(0, 15) == 0)) begin
        c_pend = 0; core_req = 1'b0;
      end else if (cg && ($urandom_range(0, 7) == 0)) begin
        c_pend = 0; c_infl = 1; core_req = 1'b0;
        core_addr = 8'($urandom); core_wdata = 8'($urandom); core_we = 1'($urandom);
      end
    end
    if (!c_pend && !c_infl && ($urandom_range(0, 2) == 0)) begin
      c_pend = 1; core_req = 1'b1; core_we = 1'($urandom);
      core_addr = 8'($urandom); core_wdata = 8'($urandom);
    end
    if (dma_ack) begin
      d_pend = 0; d_infl = 0; dma_req = 1'b0;
    end else if (d_pend) begin
      if (!dg && ($urandom_range(0, 15) == 0)) begin
        d_pend = 0; dma_req = 1'b0;
      end else if (dg && ($urandom_range(0, 7) == 0)) begin
        d_pend = 0; d_infl = 1; dma_req = 1'b0;
        dma_addr = 8'($urandom); dma_wdata = 8'($urandom); dma_we = 1'($urandom);
      end
    end
    if (!d_pend && !d_infl && ($urandom_range(0, 2) == 0)) begin
      d_pend = 1; dma_req = 1'b1; dma_we = 1'($urandom);
      dma_addr = 8'($urandom); dma_wdata = 8'($urandom);
    end
  endtask

  function automatic int ack_code();
    int code = 0;
    foreach (ack_q[i]) code = code * 4 + (ack_q[i] ? 2 : 1);
    return code;
  endfunction

  initial begin
    bit done;
    rst_n = 1'b0;
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // Core load from 0x10 holding 0xA5
    preload(8'h10, 8'hA5);
    core_req = 1; core_we = 0; core_addr = 8'h10;
    #1;
    chk("t1 stall c0", core_stall, 1);
    cycle(); chk("t1 re c1", mem_re, 1); chk("t1 stall c1", core_stall, 1);
    cycle(); chk("t1 re c2", mem_re, 1); chk("t1 stall c2", core_stall, 1);
    cycle();
    chk("t1 ack c3", core_ack, 1); chk("t1 load_en c3", load_en, 1);
    chk("t1 data c3", load_data, 8'hA5); chk("t1 stall c3", core_stall, 0);
    core_req = 0;
    cycle(); chk("t1 idle", busy, 0);

    // Core store 0x3C to 0x20
    core_req = 1; core_we = 1; core_addr = 8'h20; core_wdata = 8'h3C;
    cycle();
    chk("t2 we c1", mem_we, 1); chk("t2 addr c1", mem_addr, 8'h20);
    chk("t2 wdata c1", mem_wdata, 8'h3C);
    cycle();
    chk("t2 ack c2", core_ack, 1); chk("t2 load_en c2", load_en, 0);
    chk("t2 we c2", mem_we, 0);
    core_req = 0;
    cycle();

    // Simultaneous requests: core first, then DMA
    core_req = 1; core_we = 0; core_addr = 8'h20;
    dma_req = 1; dma_we = 1; dma_addr = 8'h44; dma_wdata = 8'h99;
    ack_q.delete();
    for (int i = 0; i < 30 && ack_q.size() < 2; i++) begin
      cycle();
      if (core_ack) core_req = 0;
      if (dma_ack) dma_req = 0;
    end
    chk("t3 order", ack_code(), 32'(1 * 4 + 2));
    chk("t3 stored", load_data, 8'h3C);
    cycle();

    // DMA held while core re-requests back to back
    core_req = 1; core_we = 0; core_addr = 8'h44;
    dma_req = 1; dma_we = 0; dma_addr = 8'h20;
    ack_q.delete();
    for (int i = 0; i < 100 && ack_q.size() < 6; i++) begin
      cycle();
      if (core_ack) core_addr = core_addr + 8'd1;
      if (core_ack && ack_q.size() >= 6) core_req = 0;
      if (dma_ack) dma_req = 0;
    end
    chk("t4 order", ack_code(), 32'(((((1 * 4 + 1) * 4 + 1) * 4 + 1) * 4 + 2) * 4 + 1));
    chk("t4 dma data", dma_rdata, 8'h3C);
    core_req = 0;
    cycle();

    // Reset during cycle 2 of a core read
    preload(8'h30, 8'h11);
    core_req = 1; core_we = 0; core_addr = 8'h30;
    cycle();
    cycle(); chk("t5 re before rst", mem_re, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 re async", mem_re, 0); chk("t5 busy async", busy, 0);
    chk("t5 ack async", core_ack, 0);
    model_reset();
    core_req = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_outputs();
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t5 no ack", core_ack, 0); chk("t5 no load_en", load_en, 0);
    end
    preload(8'h40, 8'h5A);
    core_req = 1; core_we = 0; core_addr = 8'h40;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      if (core_ack) done = 1;
    end
    chk("t5 ack seen", done, 1); chk("t5 new data", load_data, 8'h5A);
    core_req = 0;
    cycle();

    // DMA read 0x7E from 0x05
    preload(8'h05, 8'h7E);
    dma_req = 1; dma_we = 0; dma_addr = 8'h05;
    for (int k = 0; k < MEM_LAT; k++) begin
      cycle(); chk("t6 re", mem_re, 1);
    end
    cycle();
    chk("t6 ack", dma_ack, 1); chk("t6 data", dma_rdata, 8'h7E);
    chk("t6 load_data", load_data, 8'h5A); chk("t6 load_en", load_en, 0);
    dma_req = 0;
    cycle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      cycle();
    end
    core_req = 0; dma_req = 0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      if (!busy && (m_k == 0)) done = 1;
    end
    chk("drain", done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
